// File: rtl/acc_reg.sv
// Parametrised accumulator register: parallel load from the W bus, in-place
// clear/inc/dec/shift/rotate-through-carry, registered Z/N/C flags.
module acc_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    input  logic             n_write,
    input  logic [2:0]       op,
    input  logic             ea,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_CLR  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] nxt_val;
    logic             nxt_c;

    // Result of the selected in-place op; only consumed when n_write=1.
    always_comb begin
        nxt_val = acc;
        nxt_c   = flag_c;
        case (op_e'(op))
            OP_HOLD: begin
                nxt_val = acc;
                nxt_c   = flag_c;
            end
            OP_CLR: begin
                nxt_val = '0;
                nxt_c   = 1'b0;
            end
            OP_INC: {nxt_c, nxt_val} = {1'b0, acc} + {1'b0, ONE};
            OP_DEC: begin
                nxt_val = acc - ONE;
                nxt_c   = (acc == '0);
            end
            OP_SHL: begin
                nxt_val = {acc[WIDTH-2:0], 1'b0};
                nxt_c   = acc[WIDTH-1];
            end
            OP_SHR: begin
                nxt_val = {1'b0, acc[WIDTH-1:1]};
                nxt_c   = acc[0];
            end
            OP_ROL: begin
                nxt_val = {acc[WIDTH-2:0], flag_c};
                nxt_c   = acc[WIDTH-1];
            end
            OP_ROR: begin
                nxt_val = {flag_c, acc[WIDTH-1:1]};
                nxt_c   = acc[0];
            end
            default: begin
                nxt_val = acc;
                nxt_c   = flag_c;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc    <= RESET_VAL;
            flag_z <= (RESET_VAL == '0);
            flag_n <= RESET_VAL[WIDTH-1];
            flag_c <= 1'b0;
        end else if (!n_write) begin
            // Load keeps the carry: it belongs to the previous arithmetic result.
            acc    <= d;
            flag_z <= (d == '0);
            flag_n <= d[WIDTH-1];
        end else if (op != OP_HOLD) begin
            acc    <= nxt_val;
            flag_z <= (nxt_val == '0);
            flag_n <= nxt_val[WIDTH-1];
            flag_c <= nxt_c;
        end
    end

    assign alu_out = acc;
    assign bus_out = ea ? acc : {WIDTH{1'bz}};

endmodule

// File: tb/tb_acc_reg.sv
// Scoreboarded random bench for acc_reg: an 8-bit default instance and a
// 4-bit instance with a non-zero reset value, checked against an integer model.
module tb_acc_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=8, RESET_VAL=0
    logic       n_rst0 = 1'b1, n_write0 = 1'b1, ea0 = 1'b0;
    logic [7:0] d0 = '0;
    logic [2:0] op0 = '0;
    tri0  [7:0] bus0;
    logic [7:0] alu0;
    logic       z0, n0, c0;

    // DUT 1: WIDTH=4, RESET_VAL=A
    logic       n_rst1 = 1'b1, n_write1 = 1'b1, ea1 = 1'b0;
    logic [3:0] d1 = '0;
    logic [2:0] op1 = '0;
    tri0  [3:0] bus1;
    logic [3:0] alu1;
    logic       z1, n1, c1;

    acc_reg #(.WIDTH(8)) u_dut0 (
        .clk(clk), .n_rst(n_rst0), .d(d0), .n_write(n_write0), .op(op0), .ea(ea0),
        .bus_out(bus0), .alu_out(alu0), .flag_z(z0), .flag_n(n0), .flag_c(c0)
    );

    acc_reg #(.WIDTH(4), .RESET_VAL(4'hA)) u_dut1 (
        .clk(clk), .n_rst(n_rst1), .d(d1), .n_write(n_write1), .op(op1), .ea(ea1),
        .bus_out(bus1), .alu_out(alu1), .flag_z(z1), .flag_n(n1), .flag_c(c1)
    );

    typedef struct {
        int r;
        bit z, n, c, ea;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    // Behavioural model state per instance
    int mr[2];
    bit mz[2], mn[2], mc[2], mv[2];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int wid(input int w);
        return (w == 0) ? 8 : 4;
    endfunction

    // Model from the rules in plain arithmetic on integers.
    task automatic model(input int w, input bit rst, input bit nw, input int dv, input int opv);
        int W, m, r, nr;
        bit c, nc;
        W  = wid(w);
        m  = (1 << W) - 1;
        r  = mr[w];
        c  = mc[w];
        nr = r;
        nc = c;
        if (!rst) begin
            mr[w] = (w == 0) ? 0 : 'hA;
            mc[w] = 0;
            mv[w] = 1;
        end else if (!mv[w]) begin
            return;
        end else if (!nw) begin
            mr[w] = dv & m;
        end else begin
            case (opv)
                0: ;
                1: begin nr = 0; nc = 0; end
                2: begin nr = (r + 1) & m; nc = (r + 1) > m; end
                3: begin nr = (r + m) & m; nc = (r == 0); end
                4: begin nr = (r * 2) & m; nc = (r >> (W - 1)) & 1; end
                5: begin nr = r / 2; nc = r & 1; end
                6: begin nr = ((r * 2) + c) & m; nc = (r >> (W - 1)) & 1; end
                default: begin nr = (r / 2) + (c << (W - 1)); nc = r & 1; end
            endcase
            if (opv == 0) return;
            mr[w] = nr;
            mc[w] = nc;
        end
        mz[w] = (mr[w] == 0);
        mn[w] = (mr[w] >> (W - 1)) & 1;
    endtask

    // One cycle: drive instance w, park the other on hold, predict both.
    task automatic step(input int w, input bit rst, input bit nw, input int dv,
                        input int opv, input bit e);
        exp_t x;
        @(negedge clk);
        if (w == 0) begin
            n_rst0 = rst; n_write0 = nw; d0 = dv[7:0]; op0 = opv[2:0]; ea0 = e;
            n_rst1 = 1'b1; n_write1 = 1'b1; op1 = 3'd0; ea1 = 1'b0;
        end else begin
            n_rst1 = rst; n_write1 = nw; d1 = dv[3:0]; op1 = opv[2:0]; ea1 = e;
            n_rst0 = 1'b1; n_write0 = 1'b1; op0 = 3'd0; ea0 = 1'b0;
        end
        #1;
        // bus_out follows ea with no clock and still shows the pre-edge value
        if (mv[0]) chk("bus0_pre", int'(bus0), ea0 ? mr[0] : 0);
        if (mv[1]) chk("bus1_pre", int'(bus1), ea1 ? mr[1] : 0);
        if (w == 0) begin
            model(0, rst, nw, dv, opv);
            model(1, 1'b1, 1'b1, 0, 0);
        end else begin
            model(1, rst, nw, dv, opv);
            model(0, 1'b1, 1'b1, 0, 0);
        end
        if (mv[0]) begin
            x.r = mr[0]; x.z = mz[0]; x.n = mn[0]; x.c = mc[0]; x.ea = ea0;
            q0.push_back(x);
        end
        if (mv[1]) begin
            x.r = mr[1]; x.z = mz[1]; x.n = mn[1]; x.c = mc[1]; x.ea = ea1;
            q1.push_back(x);
        end
    endtask

    initial begin : mon0
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("alu0", int'(alu0), e.r);
                chk("bus0", int'(bus0), e.ea ? e.r : 0);
                chk("z0", int'(z0), int'(e.z));
                chk("n0", int'(n0), int'(e.n));
                chk("c0", int'(c0), int'(e.c));
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("alu1", int'(alu1), e.r);
                chk("bus1", int'(bus1), e.ea ? e.r : 0);
                chk("z1", int'(z1), int'(e.z));
                chk("n1", int'(n1), int'(e.n));
                chk("c1", int'(c1), int'(e.c));
            end
        end
    end

    initial begin : drive
        mv[0] = 0; mv[1] = 0;
        mr[0] = 0; mr[1] = 0;
        mc[0] = 0; mc[1] = 0;
        // reset with a load pending: reset wins
        step(0, 0, 0, 'hFF, 0, 0);
        step(0, 0, 0, 'hFF, 0, 0);
        step(0, 1, 0, 'h80, 0, 1);
        step(0, 1, 1, 0, 0, 0);
        // inc wrap, dec borrow, dec
        step(0, 1, 0, 'hFF, 0, 1);
        step(0, 1, 1, 0, 2, 1);
        step(0, 1, 1, 0, 3, 1);
        step(0, 1, 1, 0, 3, 1);
        // rotate through carry
        step(0, 1, 0, 'h81, 0, 0);
        step(0, 1, 1, 0, 6, 1);
        step(0, 1, 1, 0, 6, 1);
        step(0, 1, 1, 0, 6, 1);
        step(0, 1, 0, 'h01, 0, 1);
        step(0, 1, 1, 0, 7, 1);
        // load beats op, reset beats load
        step(0, 1, 0, 'h55, 1, 1);
        step(0, 0, 0, 'h55, 1, 1);
        // 4-bit instance, non-zero reset value
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 4, 1);
        step(1, 1, 0, 'hF, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 2, 1);
        // random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            step(int'($urandom_range(0, 1)), $urandom_range(0, 24) != 0,
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(posedge clk);
        #2;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_reg.md
Name: acc_reg

Overview:
- Parametrised accumulator register. It is the next generation of the SAP-1 8-bit accumulator (A register).
- Adds the following over the current part:
  - Generic width.
  - In-place operations: clear, increment, decrement, shifts, rotates through carry.
  - Registered Z/N/C flags.
  - Separate ports for the tri-stated bus output and the always-driven ALU output.
- Sits between the W bus and the adder/subtractor. A control-word decoder drives it.

Parameters:
- WIDTH, 8: register width in bits. Legal range is 2 or more.
- RESET_VAL, 0: value loaded into the register on reset, WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- d  input  WIDTH  data from W bus, used for load.
- n_write  input  1  load enable, active-low.
- op  input  3  in-place operation select, used only when n_write=1.
- ea  input  1  bus output enable, active-high.
- bus_out  output  WIDTH  register value when ea=1, otherwise all-Z.
- alu_out  output  WIDTH  register value, always driven (feeds the adder).
- flag_z  output  1  zero flag, registered.
- flag_n  output  1  negative flag, registered; equals MSB of the register.
- flag_c  output  1  carry flag, registered.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: when n_rst=0 at a clk rising edge, the block resets.
- Reset values:
  - reg = RESET_VAL.
  - flag_z = (RESET_VAL==0).
  - flag_n = RESET_VAL[WIDTH-1].
  - flag_c = 0.
- Reset overrides n_write and op in the same cycle. Asserting reset during a load or op discards that operation.
- Priority at each edge: n_rst=0, then n_write=0 (load), then op.
- Load (n_write=0): reg <= d. Z and N are recomputed from d. C is unchanged. op is ignored.
- op encoding when n_write=1 (C = flag_c before the edge):
  - 000 hold: reg and all flags unchanged.
  - 001 clear: reg <= 0, Z=1, N=0, C=0.
  - 010 inc: {C,reg} <= reg+1. Width is WIDTH+1; C is the carry-out.
  - 011 dec: reg <= reg-1. C=1 if reg was 0 (borrow), else C=0.
  - 100 shl: reg <= {reg[W-2:0],0}, C <= reg[W-1].
  - 101 shr logical: reg <= {0,reg[W-1:1]}, C <= reg[0].
  - 110 rol through carry: reg <= {reg[W-2:0],C}, C <= reg[W-1].
  - 111 ror through carry: reg <= {C,reg[W-1:1]}, C <= reg[0].
- For every op except hold, Z and N are recomputed from the new reg value.
- Arithmetic wraps modulo 2^WIDTH:
  - inc of all-ones gives 0 with Z=1, C=1.
  - dec of 0 gives all-ones with N=1, C=1.
- Latency:
  - Load and every op take effect one edge later.
  - alu_out and flags reflect the new value immediately after that edge.
  - bus_out is combinational on ea: it goes Z or valid in the same cycle ea changes, with no clock needed.
- n_write and op are sampled only at clk edges. Glitches between edges have no effect.
- ea has no effect on register state. The register may be loaded while ea=1; bus_out then shows the old value until the edge.
- No X may propagate from op: all 8 encodings are defined.

Test Plan:
- Hold n_rst=0 for 2 edges with n_write=0, d=8'hFF → reg=00, alu_out=00, Z=1, N=0, C=0. With ea=0, bus_out=ZZ.
- n_rst=1, n_write=0, d=8'h80, ea=1 → after the edge alu_out=80, bus_out=80, N=1, Z=0, C unchanged. Drop ea → bus_out=ZZ while alu_out stays 80.
- Load FF, then op=010 → reg=00, Z=1, C=1. Then op=011 → reg=FF, N=1, C=1 (borrow). Then op=011 → reg=FE, C=0.
- Load 81, C=0, then op=110 three times → 02/C=1, then 05/C=0, then 0A/C=0. Load 01, then op=111 → reg=00, Z=1, C=1.
- Load 55 while op=001 (n_write=0) → reg=55, not cleared. Next edge with n_write=0 and n_rst=0 → reg=00 (reset wins).
- Parameter sweep WIDTH=4, RESET_VAL=4'hA → after reset reg=A, N=1. op=100 → reg=4, C=1. op=010 five times from F wraps to 4.
